// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
//   Load/store unit bus controller. Accepts one load or store from the EX
//   stage, breaks it into one or two word-aligned bus transactions (two when
//   the access straddles a word boundary), and returns a single completion
//   pulse with the aligned, sign/zero-extended load result.
//
// Ports
//   clk_i, rst_ni          core clock, asynchronous active-low reset
//   lsu_req_i/we_i/type_i  request, store flag, {zext, size[1:0]}
//   lsu_addr_i/wdata_i     byte address, right-aligned store data
//   lsu_busy_o             high from acceptance until the completion cycle
//   lsu_rvalid_o/rdata_o   completion pulse and extended load data
//   data_req_o/gnt_i       bus request handshake
//   data_rvalid_i/rdata_i  bus response
//   data_addr_o/we_o/be_o/wdata_o  bus transaction fields (valid in REQx)
module lsu_bus_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_type_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_RESP1 = 3'd2,
    S_REQ2  = 3'd3,
    S_RESP2 = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata1;
  logic [2:0]  r_type;
  logic        r_we;

  logic [1:0]  w_off;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_split;
  logic [3:0]  w_base;
  logic [7:0]  w_mask;
  logic [63:0] w_wide_wdata;
  logic [31:0] w_addr1;
  logic [31:0] w_addr2;
  logic        w_in_req1;
  logic        w_in_req2;
  logic        w_in_resp1;
  logic        w_in_resp2;
  logic        w_done;
  logic [31:0] w_rd_lo;
  logic [23:0] w_rd_hi;
  logic [31:0] w_raw;
  logic [31:0] w_ext;

  // ---------------------------------------------------------------------------
  // Access decode from the latched request
  // ---------------------------------------------------------------------------
  assign w_off     = r_addr[1:0];
  assign w_is_byte = (r_type[1:0] == 2'b10);
  assign w_is_half = (r_type[1:0] == 2'b01);
  // Encoding 11 is reserved and behaves as a word access.
  assign w_is_word = !w_is_byte && !w_is_half;
  assign w_split   = (w_is_word && (w_off != 2'b00)) ||
                     (w_is_half && (w_off == 2'b11));

  assign w_base       = w_is_word ? 4'b1111 : (w_is_half ? 4'b0011 : 4'b0001);
  // Low nibble of the shifted mask / data belongs to the first word, high
  // nibble to the second word of a split access.
  assign w_mask       = {4'b0000, w_base} << w_off;
  assign w_wide_wdata = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_addr1      = {r_addr[31:2], 2'b00};
  assign w_addr2      = w_addr1 + 32'd4;   // wraps naturally at 2^32

  assign w_in_req1  = (r_state == S_REQ1);
  assign w_in_req2  = (r_state == S_REQ2);
  assign w_in_resp1 = (r_state == S_RESP1);
  assign w_in_resp2 = (r_state == S_RESP2);

  // ---------------------------------------------------------------------------
  // Bus outputs: driven only while a request phase is active
  // ---------------------------------------------------------------------------
  assign data_req_o   = w_in_req1 || w_in_req2;
  assign data_we_o    = data_req_o && r_we;
  assign data_addr_o  = w_in_req1 ? w_addr1 : (w_in_req2 ? w_addr2 : 32'd0);
  assign data_be_o    = w_in_req1 ? w_mask[3:0] : (w_in_req2 ? w_mask[7:4] : 4'b0000);
  assign data_wdata_o = w_in_req1 ? w_wide_wdata[31:0] :
                        (w_in_req2 ? w_wide_wdata[63:32] : 32'd0);

  // ---------------------------------------------------------------------------
  // Completion and load assembly. Completion is combinational on the bus
  // response so an aligned access finishes in the same cycle as rvalid.
  // ---------------------------------------------------------------------------
  assign w_done = (w_in_resp1 && data_rvalid_i && !w_split) ||
                  (w_in_resp2 && data_rvalid_i);

  // In RESP1 the response is the low word; in RESP2 it is the high word and
  // the low word comes from the first transaction. Only the low three bytes
  // of the high word can ever reach the result.
  assign w_rd_lo = w_in_resp2 ? r_rdata1 : data_rdata_i;
  assign w_rd_hi = w_in_resp2 ? data_rdata_i[23:0] : 24'd0;

  always_comb begin
    w_raw = w_rd_lo;
    case (w_off)
      2'd0:    w_raw = w_rd_lo;
      2'd1:    w_raw = {w_rd_hi[7:0],  w_rd_lo[31:8]};
      2'd2:    w_raw = {w_rd_hi[15:0], w_rd_lo[31:16]};
      default: w_raw = {w_rd_hi[23:0], w_rd_lo[31:24]};
    endcase
  end

  always_comb begin
    w_ext = w_raw;
    if (w_is_byte) begin
      w_ext = {{24{~r_type[2] & w_raw[7]}}, w_raw[7:0]};
    end else if (w_is_half) begin
      w_ext = {{16{~r_type[2] & w_raw[15]}}, w_raw[15:0]};
    end
  end

  assign lsu_rvalid_o = w_done;
  assign lsu_rdata_o  = (w_done && !r_we) ? w_ext : 32'd0;
  assign lsu_busy_o   = (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM and request latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata1 <= 32'd0;
      r_type   <= 3'd0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu_req_i) begin
            r_addr  <= lsu_addr_i;
            r_wdata <= lsu_wdata_i;
            r_type  <= lsu_type_i;
            r_we    <= lsu_we_i;
            r_state <= S_REQ1;
          end
        end
        S_REQ1: begin
          if (data_gnt_i) r_state <= S_RESP1;
        end
        S_RESP1: begin
          if (data_rvalid_i) begin
            r_rdata1 <= data_rdata_i;
            r_state  <= w_split ? S_REQ2 : S_IDLE;
          end
        end
        S_REQ2: begin
          if (data_gnt_i) r_state <= S_RESP2;
        end
        S_RESP2: begin
          if (data_rvalid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl
//   Directed testbench for lsu_bus_ctrl. Inputs change just after the falling
//   edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_lsu_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_type_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_wdata_i = 32'd0;
  logic        lsu_busy_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = 32'd0;

  int total = 0;
  int bad   = 0;

  lsu_bus_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_type_i   (lsu_type_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_busy_o   (lsu_busy_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_rdata_i (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus outputs idle and no completion.
  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk({tag, ".busy"},   {31'd0, lsu_busy_o},   {31'd0, exp_busy});
    chk({tag, ".req"},    {31'd0, data_req_o},   32'd0);
    chk({tag, ".we"},     {31'd0, data_we_o},    32'd0);
    chk({tag, ".be"},     {28'd0, data_be_o},    32'd0);
    chk({tag, ".rvalid"}, {31'd0, lsu_rvalid_o}, 32'd0);
    chk({tag, ".rdata"},  lsu_rdata_o,           32'd0);
  endtask

  task automatic accept(input logic we, input logic [2:0] ty,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = ty;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    #1;
    chk("accept.busy", {31'd0, lsu_busy_o}, 32'd0);
  endtask

  // Request-phase cycle: check the bus fields, optionally grant.
  task automatic req_cycle(input string tag, input logic gnt, input logic stray_rv,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic exp_we, input logic [31:0] wmask,
                           input logic [31:0] exp_wdata);
    @(negedge clk_i);
    lsu_req_i = 1'b0; data_gnt_i = gnt; data_rvalid_i = stray_rv;
    #1;
    chk({tag, ".req"},   {31'd0, data_req_o},   32'd1);
    chk({tag, ".addr"},  data_addr_o,           exp_addr);
    chk({tag, ".be"},    {28'd0, data_be_o},    {28'd0, exp_be});
    chk({tag, ".we"},    {31'd0, data_we_o},    {31'd0, exp_we});
    chk({tag, ".wdata"}, data_wdata_o & wmask,  exp_wdata);
    chk({tag, ".busy"},  {31'd0, lsu_busy_o},   32'd1);
    chk({tag, ".rv"},    {31'd0, lsu_rvalid_o}, 32'd0);
  endtask

  // Response-phase cycle: drive the bus response and check the completion.
  task automatic resp_cycle(input string tag, input logic rv, input logic [31:0] rdata,
                            input logic exp_done, input logic [31:0] exp_rdata);
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = rv; data_rdata_i = rdata;
    #1;
    chk({tag, ".req"},    {31'd0, data_req_o},   32'd0);
    chk({tag, ".busy"},   {31'd0, lsu_busy_o},   32'd1);
    chk({tag, ".rvalid"}, {31'd0, lsu_rvalid_o}, {31'd0, exp_done});
    chk({tag, ".rdata"},  lsu_rdata_o,           exp_rdata);
  endtask

  task automatic finish_idle(input string tag);
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
    #1;
    chk_quiet(tag, 1'b0);
  endtask

  task automatic single(input string tag, input logic we, input logic [2:0] ty,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] wmask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    accept(we, ty, addr, wdata);
    req_cycle({tag, ".req1"}, 1'b1, 1'b0, exp_addr, exp_be, we, wmask, exp_wdata);
    resp_cycle({tag, ".resp1"}, 1'b1, rdata, 1'b1, exp_rdata);
    finish_idle({tag, ".idle"});
    $display("txn %s addr=%h done", tag, addr);
  endtask

  initial begin
    // Reset state
    #2;
    chk_quiet("reset", 1'b0);
    chk("reset.addr",  data_addr_o,  32'd0);
    chk("reset.wdata", data_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    $display("txn reset released");

    // Aligned accesses
    single("lw_100",  1'b0, 3'b000, 32'h0000_0100, 32'd0, 32'h8000_00FF,
           32'h0000_0100, 4'b1111, 32'd0, 32'd0, 32'h8000_00FF);
    single("lb_203",  1'b0, 3'b010, 32'h0000_0203, 32'd0, 32'h8012_3456,
           32'h0000_0200, 4'b1000, 32'd0, 32'd0, 32'hFFFF_FF80);
    single("lbu_203", 1'b0, 3'b110, 32'h0000_0203, 32'd0, 32'h8012_3456,
           32'h0000_0200, 4'b1000, 32'd0, 32'd0, 32'h0000_0080);
    single("lh_002",  1'b0, 3'b001, 32'h0000_0002, 32'd0, 32'h8001_5555,
           32'h0000_0000, 4'b1100, 32'd0, 32'd0, 32'hFFFF_8001);
    single("lhu_002", 1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'h8001_5555,
           32'h0000_0000, 4'b1100, 32'd0, 32'd0, 32'h0000_8001);
    single("sb_012",  1'b1, 3'b010, 32'h0000_0012, 32'h1234_565A, 32'hDEAD_BEEF,
           32'h0000_0010, 4'b0100, 32'h00FF_0000, 32'h005A_0000, 32'd0);
    single("sh_006",  1'b1, 3'b001, 32'h0000_0006, 32'hFFFF_BEEF, 32'hDEAD_BEEF,
           32'h0000_0004, 4'b1100, 32'hFFFF_0000, 32'hBEEF_0000, 32'd0);
    single("lw_rsv",  1'b0, 3'b111, 32'h0000_0008, 32'd0, 32'h7654_3210,
           32'h0000_0008, 4'b1111, 32'd0, 32'd0, 32'h7654_3210);

    // Split store: SW 0x101
    accept(1'b1, 3'b000, 32'h0000_0101, 32'hAABB_CCDD);
    req_cycle("sw_101.req1", 1'b1, 1'b0, 32'h0000_0100, 4'b1110, 1'b1,
              32'hFFFF_FF00, 32'hBBCC_DD00);
    resp_cycle("sw_101.resp1", 1'b1, 32'h0, 1'b0, 32'd0);
    req_cycle("sw_101.req2", 1'b1, 1'b0, 32'h0000_0104, 4'b0001, 1'b1,
              32'h0000_00FF, 32'h0000_00AA);
    resp_cycle("sw_101.resp2", 1'b1, 32'h0, 1'b1, 32'd0);
    finish_idle("sw_101.idle");
    $display("txn sw_101 split done");

    // Split load wrapping the address space: LH 0xFFFFFFFF
    accept(1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0);
    req_cycle("lh_wrap.req1", 1'b1, 1'b0, 32'hFFFF_FFFC, 4'b1000, 1'b0, 32'd0, 32'd0);
    resp_cycle("lh_wrap.resp1", 1'b1, 32'h12AB_CDEF, 1'b0, 32'd0);
    req_cycle("lh_wrap.req2", 1'b1, 1'b0, 32'h0000_0000, 4'b0001, 1'b0, 32'd0, 32'd0);
    resp_cycle("lh_wrap.resp2", 1'b1, 32'h9988_7734, 1'b1, 32'h0000_3412);
    finish_idle("lh_wrap.idle");
    $display("txn lh_wrap split done");

    // Stalled grant (3 cycles, stray rvalid in the first) and delayed rvalid
    accept(1'b0, 3'b000, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 3; i++)
      req_cycle("stall.wait", 1'b0, (i == 0), 32'h0000_0040, 4'b1111, 1'b0, 32'd0, 32'd0);
    req_cycle("stall.gnt", 1'b1, 1'b0, 32'h0000_0040, 4'b1111, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++)
      resp_cycle("stall.rwait", 1'b0, 32'h0, 1'b0, 32'd0);
    resp_cycle("stall.resp", 1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
    finish_idle("stall.idle");
    $display("txn stall done");

    // Reset in RESP1 of a split load, then a stray rvalid
    accept(1'b0, 3'b000, 32'h0000_0102, 32'd0);
    req_cycle("rst.req1", 1'b1, 1'b0, 32'h0000_0100, 4'b1100, 1'b0, 32'd0, 32'd0);
    @(negedge clk_i);
    data_gnt_i = 1'b0; rst_ni = 1'b0;
    #1;
    chk_quiet("rst.asserted", 1'b0);
    chk("rst.addr",  data_addr_o,  32'd0);
    chk("rst.wdata", data_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
    #1;
    chk_quiet("rst.stray", 1'b0);
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    #1;
    chk_quiet("rst.after", 1'b0);
    $display("txn reset_mid_split done");
    single("lw_300", 1'b0, 3'b000, 32'h0000_0300, 32'd0, 32'h1122_3344,
           32'h0000_0300, 4'b1111, 32'd0, 32'd0, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
